fwd_history_unit: RTL and testbench
===================================

# fwd_history_unit

Parametrised operand-forwarding unit for the X stage. It supplies bypassed source-register values, including store data, for NUM_SRC source operands. Alongside the live writeback result, it keeps an internal history of the last DEPTH committed register writes, so any operand whose producer is up to DEPTH+1 instructions older resolves without waiting on the register file. It sits between the register-file read ports and the ALU/store-data muxes. It also keeps a saturating count of forwarded operands for performance monitoring.

## Interface
- XLEN, 32, datapath width
- DEPTH, 2, number of retained history entries (legal range 1..4); DEPTH=1 gives writeback + one previous write
- NUM_SRC, 2, number of source operands looked up per cycle (legal range 1..3)
- CNT_W, 16, width of the forward-hit performance counter
- LW (localparam), $clog2(DEPTH+2), width of each level code

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hold the history; no shift, no capture
- flush  in  1  invalidate all history entries
- wb_valid  in  1  a register write commits this cycle (the caller excludes branch and store opcodes)
- wb_rd  in  5  destination register of the committing write
- wb_data  in  XLEN  value being written
- src_idx  in  NUM_SRC*5  source register indices; operand s is in bits [5s+4:5s]
- src_rf_data  in  NUM_SRC*XLEN  register-file read data, one XLEN slice per operand
- fwd_data  out  NUM_SRC*XLEN  resolved operand values
- fwd_hit  out  NUM_SRC  operand s was taken from a bypass, not the register file
- fwd_level  out  NUM_SRC*LW  0 = register file; 1 = live writeback; k+2 = history entry k
- hit_count  out  CNT_W  saturating count of forwarded operands

## Operation
- History is a shift register entry[0..DEPTH-1]. Each entry holds {valid, rd[4:0], data[XLEN-1:0]}. entry[0] is the youngest.
- Capture and shift happen when stall=0 and flush=0:
  - entry[0] <= {wb_valid && wb_rd!=0, wb_rd, wb_data}
  - entry[i] <= entry[i-1] for i ≥ 1
  - The oldest entry drops off.
- stall=1 and flush=0: all entries hold.
- flush=1: all valid bits clear next edge. rd and data are don't-care. flush wins over stall.
- Lookup is combinational and independent for each operand s, in priority order:
  1. src_idx[s]==0: never forward. Result is src_rf_data slice, level 0.
  2. wb_valid && wb_rd!=0 && wb_rd==src_idx[s]: result is wb_data, level 1.
  3. Otherwise, the lowest k with entry[k].valid && entry[k].rd==src_idx[s]: result is entry[k].data, level k+2. The youngest match wins.
  4. Otherwise: src_rf_data, level 0.
- fwd_hit[s] = (fwd_level[s] != 0).
- hit_count increments by popcount(fwd_hit) on each edge with stall=0. It saturates at 2^CNT_W-1 and never wraps. Flush does not clear it.
- The same source index on several operands resolves identically on every operand.

## Timing
- Lookup has zero latency: fwd_* are valid in the same cycle as src_idx, wb_*, and the history state.
- A write presented with wb_valid=1 in cycle n:
  - forwards at level 1 in cycle n;
  - forwards at level 2 in cycle n+1 (if not stalled);
  - forwards at level k+2 after k+1 unstalled edges;
  - is gone after DEPTH+1 unstalled edges.
- Reset, while reset_n=0:
  - all entry valid/rd/data = 0 and hit_count = 0;
  - fwd_hit = 0, fwd_level = 0, and fwd_data = src_rf_data (the live path is also gated).
- Reset asserted mid-stream discards the whole history immediately. The first edge after release captures normally.
- Simultaneous flush with wb_valid=1: the write still forwards at level 1 in that cycle but is not captured.
- Stall with wb_valid=1: the write forwards at level 1 each cycle but is captured only on the first unstalled edge.
- No illegal state or overflow exists other than counter saturation.

## Test plan
- Back-to-back RAW, DEPTH=2. Stream writes:
  - x5=0x11 in cycle 0, x6=0x22 in cycle 1, x7=0x33 in cycle 2.
  - In cycle 2, with src_idx={x5,x7} and rf=0xDEAD: fwd_data={0x11,0x33}, levels {3,1}.
  - In cycle 3 with no write: x5 resolves to 0xDEAD, level 0.
- Youngest-match priority:
  - x9=0xA in cycle 0, x9=0xB in cycle 1, no write in cycle 2.
  - Reading x9 in cycle 2 gives 0xB at level 2.
  - Reading x9 in cycle 1 gives 0xB at level 1.
- x0 and invalid writes:
  - wb_valid=1, wb_rd=0, wb_data=0xFFFF_FFFF; later read src_idx=0: rf data, hit=0.
  - wb_valid=0 with wb_rd=4; read x4: rf data.
- Stall and flush:
  - Capture x3=0x77, then hold stall=1 for 3 cycles: x3 stays at level 2.
  - Assert flush together with stall: next cycle x3 gives rf data, and hit_count is unchanged by the flush.
- Counter saturation, CNT_W=4, NUM_SRC=2: force both operands to hit for 9 cycles. hit_count reads 14 after 7 cycles, then stays at 15.
- Asynchronous reset mid-stream: assert reset_n=0 between edges. fwd_hit drops to 0 combinationally and hit_count reads 0. After release, the old history never reappears.

Source files
------------

// File: rtl/fwd_history_unit.sv
// Operand forwarding for the X stage: live writeback bypass plus a shift-register
// history of the last DEPTH committed writes, with a saturating forward-hit counter.
module fwd_history_unit #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 2,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16,
  localparam int LW     = $clog2(DEPTH + 2)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    wb_valid,
  input  logic [4:0]              wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic [NUM_SRC*5-1:0]    src_idx,
  input  logic [NUM_SRC*XLEN-1:0] src_rf_data,
  output logic [NUM_SRC*XLEN-1:0] fwd_data,
  output logic [NUM_SRC-1:0]      fwd_hit,
  output logic [NUM_SRC*LW-1:0]   fwd_level,
  output logic [CNT_W-1:0]        hit_count
);

  localparam int PW = $clog2(NUM_SRC + 1);

  logic            r_vld  [DEPTH];
  logic [4:0]      r_rd   [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic       w_wb_live;
  logic [4:0] w_idx [NUM_SRC];
  logic [PW-1:0] w_pop;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [PW-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(b);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Writes to x0 are never live and never enter the history.
  assign w_wb_live = wb_valid && (wb_rd != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i]  <= 1'b0;
        r_rd[i]   <= 5'd0;
        r_data[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_vld[i] <= 1'b0;
    end else if (!stall) begin
      r_vld[0]  <= w_wb_live;
      r_rd[0]   <= wb_rd;
      r_data[0] <= wb_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_rd[i]   <= r_rd[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) w_idx[s] = src_idx[5*s +: 5];
  end

  // Oldest-to-youngest scan so the youngest match overrides; live wb overrides all.
  always_comb begin
    fwd_data  = src_rf_data;
    fwd_level = '0;
    fwd_hit   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_vld[k] && (r_rd[k] == w_idx[s])) begin
          fwd_data[s*XLEN +: XLEN] = r_data[k];
          fwd_level[s*LW +: LW]    = LW'(k + 2);
        end
      end
      if (w_wb_live && (wb_rd == w_idx[s])) begin
        fwd_data[s*XLEN +: XLEN] = wb_data;
        fwd_level[s*LW +: LW]    = LW'(1);
      end
      if (!reset_n || (w_idx[s] == 5'd0)) begin
        fwd_data[s*XLEN +: XLEN] = src_rf_data[s*XLEN +: XLEN];
        fwd_level[s*LW +: LW]    = '0;
      end
      fwd_hit[s] = (fwd_level[s*LW +: LW] != '0);
    end
  end

  always_comb begin
    w_pop = '0;
    for (int s = 0; s < NUM_SRC; s++) w_pop = w_pop + PW'(fwd_hit[s]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_cnt <= '0;
    else if (!stall) r_cnt <= sat_add(r_cnt, w_pop);
  end

  assign hit_count = r_cnt;

endmodule

// File: tb/tb_fwd_history_unit.sv
// Directed bench for fwd_history_unit (DEPTH=2, NUM_SRC=2) plus a CNT_W=4 copy
// used to observe counter saturation.
module tb_fwd_history_unit;

  localparam logic [31:0] RF0 = 32'h0000_DEAD;
  localparam logic [31:0] RF1 = 32'h0000_BEEF;

  logic        clk = 1'b0;
  logic        reset_n, stall, flush, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [9:0]  src_idx;
  logic [63:0] src_rf_data;
  logic [63:0] fwd_data, s_fwd_data;
  logic [1:0]  fwd_hit, s_fwd_hit;
  logic [3:0]  fwd_level, s_fwd_level;
  logic [15:0] hit_count;
  logic [3:0]  s_hit_count;

  int ntests = 0;
  int nfail  = 0;
  int cnt    = 0;

  always #5 clk = ~clk;

  fwd_history_unit #(.XLEN(32), .DEPTH(2), .NUM_SRC(2), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .src_idx(src_idx), .src_rf_data(src_rf_data),
    .fwd_data(fwd_data), .fwd_hit(fwd_hit), .fwd_level(fwd_level),
    .hit_count(hit_count)
  );

  fwd_history_unit #(.XLEN(32), .DEPTH(2), .NUM_SRC(2), .CNT_W(4)) u_sat (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .src_idx(src_idx), .src_rf_data(src_rf_data),
    .fwd_data(s_fwd_data), .fwd_hit(s_fwd_hit), .fwd_level(s_fwd_level),
    .hit_count(s_hit_count)
  );

  typedef struct {
    logic        st, fl, wv;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  i0, i1;
    logic [31:0] d0, d1;
    logic [1:0]  l0, l1;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(logic st, logic fl, logic wv, logic [4:0] rd,
                              logic [31:0] wd, logic [4:0] i0, logic [31:0] d0,
                              logic [1:0] l0, logic [4:0] i1, logic [31:0] d1,
                              logic [1:0] l1);
    vec_t v;
    v.st = st; v.fl = fl; v.wv = wv; v.rd = rd; v.wd = wd;
    v.i0 = i0; v.d0 = d0; v.l0 = l0; v.i1 = i1; v.d1 = d1; v.l1 = l1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic fl, input logic wv, input logic [4:0] rd,
                       input logic [31:0] wd, input logic [4:0] i0, input logic [4:0] i1);
    stall = st; flush = fl; wb_valid = wv; wb_rd = rd; wb_data = wd;
    src_idx = {i1, i0};
    src_rf_data = {RF1, RF0};
  endtask

  initial begin
    // Vectors: st fl wv rd data | i0 d0 l0 | i1 d1 l1
    tbl[0]  = mk(0,0,1, 5, 32'h11,       5, 32'h11, 1,  0, RF1,    0);
    tbl[1]  = mk(0,0,1, 6, 32'h22,       5, 32'h11, 2,  6, 32'h22, 1);
    tbl[2]  = mk(0,0,1, 7, 32'h33,       5, 32'h11, 3,  7, 32'h33, 1);
    tbl[3]  = mk(0,0,0, 0, 32'h0,        5, RF0,    0,  6, 32'h22, 3);
    tbl[4]  = mk(0,0,0, 0, 32'h0,        7, 32'h33, 3,  6, RF1,    0);
    tbl[5]  = mk(0,0,1, 9, 32'hA,        9, 32'hA,  1,  9, 32'hA,  1);
    tbl[6]  = mk(0,0,1, 9, 32'hB,        9, 32'hB,  1,  9, 32'hB,  1);
    tbl[7]  = mk(0,0,0, 0, 32'h0,        9, 32'hB,  2,  9, 32'hB,  2);
    tbl[8]  = mk(0,0,0, 0, 32'h0,        9, 32'hB,  3,  0, RF1,    0);
    tbl[9]  = mk(0,0,1, 0, 32'hFFFF_FFFF,0, RF0,    0,  0, RF1,    0);
    tbl[10] = mk(0,0,0, 4, 32'h44,       4, RF0,    0,  0, RF1,    0);
    tbl[11] = mk(0,0,0, 0, 32'h0,        0, RF0,    0,  4, RF1,    0);
    tbl[12] = mk(0,0,1, 3, 32'h77,       3, 32'h77, 1,  0, RF1,    0);
    tbl[13] = mk(1,0,0, 0, 32'h0,        3, 32'h77, 2,  3, 32'h77, 2);
    tbl[14] = mk(1,0,0, 0, 32'h0,        3, 32'h77, 2,  3, 32'h77, 2);
    tbl[15] = mk(1,0,0, 0, 32'h0,        3, 32'h77, 2,  3, 32'h77, 2);
    tbl[16] = mk(1,1,1, 8, 32'h88,       3, 32'h77, 2,  8, 32'h88, 1);
    tbl[17] = mk(0,0,0, 0, 32'h0,        3, RF0,    0,  8, RF1,    0);
    tbl[18] = mk(1,0,1,10, 32'h100,     10, 32'h100,1,  0, RF1,    0);
    tbl[19] = mk(1,0,1,10, 32'h100,     10, 32'h100,1,  0, RF1,    0);
    tbl[20] = mk(0,0,1,10, 32'h100,     10, 32'h100,1,  0, RF1,    0);
    tbl[21] = mk(0,0,0, 0, 32'h0,       10, 32'h100,2, 10, 32'h100,2);
    tbl[22] = mk(0,0,0, 0, 32'h0,       10, 32'h100,3, 10, 32'h100,3);
    tbl[23] = mk(0,0,0, 0, 32'h0,       10, RF0,    0, 10, RF1,    0);

    // Reset state: live path is gated even with a matching write.
    reset_n = 1'b0;
    drive(0, 0, 1, 5, 32'h55, 5, 5);
    #1;
    chk("rst_hit", 64'(fwd_hit), 64'd0);
    chk("rst_level", 64'(fwd_level), 64'd0);
    chk("rst_data", fwd_data, {RF1, RF0});
    chk("rst_cnt", 64'(hit_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 24; n++) begin
      drive(tbl[n].st, tbl[n].fl, tbl[n].wv, tbl[n].rd, tbl[n].wd, tbl[n].i0, tbl[n].i1);
      #1;
      chk($sformatf("v%0d_data0", n), 64'(fwd_data[31:0]), 64'(tbl[n].d0));
      chk($sformatf("v%0d_data1", n), 64'(fwd_data[63:32]), 64'(tbl[n].d1));
      chk($sformatf("v%0d_level", n), 64'(fwd_level), 64'({tbl[n].l1, tbl[n].l0}));
      chk($sformatf("v%0d_hit", n), 64'(fwd_hit),
          64'({tbl[n].l1 != 2'd0, tbl[n].l0 != 2'd0}));
      chk($sformatf("v%0d_cnt", n), 64'(hit_count), 64'(cnt));
      if (!tbl[n].st) cnt = cnt + int'(tbl[n].l0 != 2'd0) + int'(tbl[n].l1 != 2'd0);
      @(negedge clk);
    end

    // Asynchronous reset between edges discards history immediately.
    drive(0, 0, 1, 12, 32'h5, 12, 12);
    @(negedge clk);
    drive(0, 0, 1, 13, 32'h6, 12, 13);
    #1;
    chk("pre_rst_level", 64'(fwd_level), 64'({2'd1, 2'd2}));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_hit", 64'(fwd_hit), 64'd0);
    chk("arst_level", 64'(fwd_level), 64'd0);
    chk("arst_data", fwd_data, {RF1, RF0});
    chk("arst_cnt", 64'(hit_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 12, 13);
    #1;
    chk("post_rst_data", fwd_data, {RF1, RF0});
    chk("post_rst_hit", 64'(fwd_hit), 64'd0);
    @(negedge clk);
    drive(0, 0, 1, 14, 32'h7, 14, 12);
    #1;
    chk("post_rst_wb", 64'({fwd_level, fwd_data[31:0]}), 64'({2'd0, 2'd1, 32'h7}));
    @(negedge clk);
    drive(0, 0, 0, 0, 32'h0, 14, 12);
    #1;
    chk("post_rst_hist", 64'({fwd_level, fwd_data[31:0]}), 64'({2'd0, 2'd2, 32'h7}));
    chk("post_rst_cnt", 64'(hit_count), 64'd1);
    @(negedge clk);

    // Counter saturation on the CNT_W=4 copy; wide copy keeps counting.
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 1, 1, 32'h1, 1, 1);
      @(posedge clk);
      #1;
      chk($sformatf("sat_cnt%0d", i + 1), 64'(s_hit_count),
          64'(((2 * (i + 1)) > 15) ? 15 : (2 * (i + 1))));
      chk($sformatf("wide_cnt%0d", i + 1), 64'(hit_count), 64'(2 * (i + 1)));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
